// File: rtl/gbar_unit.sv
// ----------------------------------------------------------------------------
// gbar_unit -- cluster-level global barrier responder.
//
// Accepts one barrier arrival per cycle from the attached cores. The core is
// chosen round-robin. The unit tracks which cores have arrived at each
// barrier. When the requested participant count is reached, it broadcasts a
// single-cycle release pulse carrying the barrier ID.
//
// Ports
//   clk          in   clock
//   reset_n      in   asynchronous active-low reset
//   req_valid    in   [NUM_CORES]            per-core arrival request
//   req_id       in   [NUM_CORES][NB_WIDTH]  barrier ID per core
//   req_size_m1  in   [NUM_CORES][NC_WIDTH]  participant count minus one
//   req_core_id  in   [NUM_CORES][NC_WIDTH]  sender index (equals port index)
//   req_ready    out  [NUM_CORES]            one-hot grant (combinational)
//   rsp_valid    out  release pulse
//   rsp_id       out  [NB_WIDTH] released barrier ID
//   err_dup      out  pulse: duplicate arrival was dropped
//   busy         out  any barrier partially filled or a release in flight
// ----------------------------------------------------------------------------
module gbar_unit #(
   parameter int NUM_CORES    = 4,
   parameter int NUM_BARRIERS = 8,
   parameter int NB_WIDTH     = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1,
   parameter int NC_WIDTH     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic [NUM_CORES-1:0]               req_valid,
   input  logic [NUM_CORES-1:0][NB_WIDTH-1:0] req_id,
   input  logic [NUM_CORES-1:0][NC_WIDTH-1:0] req_size_m1,
   input  logic [NUM_CORES-1:0][NC_WIDTH-1:0] req_core_id,
   output logic [NUM_CORES-1:0]               req_ready,
   output logic                               rsp_valid,
   output logic [NB_WIDTH-1:0]                rsp_id,
   output logic                               err_dup,
   output logic                               busy
);

   // Per-barrier arrival state
   logic [NUM_BARRIERS-1:0][NUM_CORES-1:0] arr_mask;
   logic [NUM_BARRIERS-1:0][NC_WIDTH:0]    arr_cnt;
   logic [NUM_BARRIERS-1:0][NC_WIDTH-1:0]  size_m1;
   logic [NC_WIDTH-1:0]                    rr_ptr;

   // Stage p0: arbitration and decision on the granted request
   logic                gnt_any_p0;
   logic [NC_WIDTH-1:0] gnt_idx_p0;
   logic [NC_WIDTH-1:0] rr_nxt_p0;
   logic [NB_WIDTH-1:0] acc_id_p0;
   logic [NC_WIDTH-1:0] acc_sz_p0;
   logic [NC_WIDTH-1:0] eff_sz_p0;
   logic                acc_dup_p0;
   logic                acc_first_p0;
   logic                acc_done_p0;

   // Stage p1: registered outputs
   logic                vld_p1;
   logic [NB_WIDTH-1:0] rsp_id_p1;
   logic                err_dup_p1;

   always_comb begin
      int k;
      gnt_any_p0 = 1'b0;
      gnt_idx_p0 = '0;
      k          = 0;
      for (int i = 0; i < NUM_CORES; i++) begin
         k = int'(rr_ptr) + i;
         if (k >= NUM_CORES) k = k - NUM_CORES;
         if (!gnt_any_p0 && req_valid[NC_WIDTH'(k)]) begin
            gnt_any_p0 = 1'b1;
            gnt_idx_p0 = NC_WIDTH'(k);
         end
      end
   end

   // Grants are held off while reset is asserted.
   always_comb begin
      req_ready = '0;
      if (gnt_any_p0 && reset_n) req_ready[gnt_idx_p0] = 1'b1;
   end

   assign rr_nxt_p0 = (gnt_idx_p0 == NC_WIDTH'(NUM_CORES - 1)) ? '0 : gnt_idx_p0 + 1'b1;

   // The size is latched by the first arrival. Later arrivals compare
   // against the stored size, so a disagreeing size_m1 from a latecomer is ignored.
   always_comb begin
      acc_id_p0    = req_id[gnt_idx_p0];
      acc_sz_p0    = req_size_m1[gnt_idx_p0];
      acc_dup_p0   = arr_mask[acc_id_p0][gnt_idx_p0];
      acc_first_p0 = (arr_cnt[acc_id_p0] == '0);
      eff_sz_p0    = acc_first_p0 ? acc_sz_p0 : size_m1[acc_id_p0];
      acc_done_p0  = (arr_cnt[acc_id_p0] == {1'b0, eff_sz_p0});
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         arr_mask   <= '0;
         arr_cnt    <= '0;
         size_m1    <= '0;
         rr_ptr     <= '0;
         vld_p1     <= 1'b0;
         rsp_id_p1  <= '0;
         err_dup_p1 <= 1'b0;
      end else begin
         vld_p1     <= 1'b0;
         err_dup_p1 <= 1'b0;
         if (gnt_any_p0) begin
            rr_ptr <= rr_nxt_p0;
            if (acc_dup_p0) begin
               err_dup_p1 <= 1'b1;
            end else begin
               if (acc_first_p0) size_m1[acc_id_p0] <= acc_sz_p0;
               if (acc_done_p0) begin
                  arr_mask[acc_id_p0] <= '0;
                  arr_cnt[acc_id_p0]  <= '0;
                  vld_p1              <= 1'b1;
                  rsp_id_p1           <= acc_id_p0;
               end else begin
                  arr_mask[acc_id_p0][gnt_idx_p0] <= 1'b1;
                  arr_cnt[acc_id_p0]              <= arr_cnt[acc_id_p0] + 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      busy = vld_p1;
      for (int b = 0; b < NUM_BARRIERS; b++) begin
         if (arr_cnt[b] != '0) busy = 1'b1;
      end
   end

   assign rsp_valid = vld_p1;
   assign rsp_id    = rsp_id_p1;
   assign err_dup   = err_dup_p1;

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (reset_n && gnt_any_p0) begin
         assert (req_core_id[gnt_idx_p0] == gnt_idx_p0)
            else $error("gbar_unit: req_core_id does not match granted port");
      end
   end
`endif

endmodule
